zap_wb_ram_responder: RTL
=========================

Name: zap_wb_ram_responder

Overview:
- Synthesizable Wishbone B3 slave (responder) that serves the Wishbone transactions issued by the ZAP memory-side initiators: TLB page-table walks and cache line fills/writebacks.
- Backed by a word-addressed on-chip RAM.
- Supports programmable wait states, byte selects, registered-feedback incrementing/wrapping bursts and out-of-range error responses.
- Used as boot/page-table RAM in SoC integration and as the bus-accurate memory in block-level benches.

Parameters:
- DEPTH_WORDS, 4096, RAM depth in 32-bit words; power of 2, >= 16.
- BASE_ADDR, 32'h0000_0000, byte base address; aligned to 4*DEPTH_WORDS.
- WAIT_STATES, 1, extra cycles before the first beat of each transaction; range 0..15.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_wb_cyc  in  1  bus cycle valid.
- i_wb_stb  in  1  strobe.
- i_wb_wen  in  1  1=write, 0=read.
- i_wb_adr  in  32  byte address; [1:0] ignored.
- i_wb_sel  in  4  byte lane enables; [i] covers bits 8i+7:8i.
- i_wb_dat  in  32  write data.
- i_wb_cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- i_wb_bte  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- o_wb_dat  out  32  read data, valid with o_wb_ack.
- o_wb_ack  out  1  normal termination.
- o_wb_err  out  1  error termination.

Behaviour:
- Reset (i_reset==0 at an edge):
  - Outputs after the edge: o_wb_ack=0, o_wb_err=0, o_wb_dat=0; state IDLE; counters 0.
  - RAM contents not reset.
  - Reset mid-transaction aborts it with no ack and no write.
- All outputs are registered.
- FSM states: IDLE, WAIT, BEAT, BURST.
- IDLE:
  - At an edge with cyc&stb=1: latch adr, wen, sel, dat, cti, bte.
  - Range check: in range iff BASE_ADDR <= adr < BASE_ADDR+4*DEPTH_WORDS.
  - WAIT_STATES==0 -> BEAT. Otherwise -> WAIT with cnt=WAIT_STATES-1.
- WAIT:
  - cnt decrements each cycle; at cnt==0 -> BEAT.
  - First ack/err is therefore high during the cycle following edge N+WAIT_STATES, where N is the sampling edge.
- BEAT (the edge entering this state performs the access):
  - Read: o_wb_dat = RAM[word index].
  - Write: only lanes with sel=1 are updated; unselected bytes are unchanged.
  - Write commits on the same edge that raises o_wb_ack. Read-after-write to the same word returns the new data.
  - Out of range: o_wb_err=1 instead of ack, no write, o_wb_dat=0, then IDLE. Any burst is dropped.
  - After an ack with latched cti==010 -> BURST. Otherwise -> IDLE (ack/err high exactly one cycle).
- BURST:
  - Internal address = previous + 4, computed by the sub-module.
  - Wrap bte: only low bits [3:2]/[4:2]/[5:2] increment; upper bits held.
  - Linear bte: word index wraps modulo DEPTH_WORDS; an out-of-range beat errors.
  - i_wb_adr is ignored after the first beat.
  - Each cycle with cyc&stb=1: one beat with ack in the next cycle, so back-to-back beats add no wait states.
  - Sampled cti==111 ends the burst: that beat is acked, then IDLE.
  - stb=0 with cyc=1: master wait; hold state and address, ack=0.
- cyc deasserted in any non-IDLE state:
  - -> IDLE at that edge; ack/err forced 0; pending access not performed.
  - A beat already acked is not undone.
- Simultaneous events:
  - New cyc&stb in the same cycle an ack/err is high for a classic cycle: ignored. The responder accepts a new request only from IDLE.
  - ack and err never high together.
- Width rules:
  - Word index = (adr - BASE_ADDR)[log2(4*DEPTH_WORDS)-1:2].
  - Unused address bits are OR-reduced into an unused signal.

Decomposition:
- zap_wb_pkg (shared package):
  - CTI_CLASSIC/CTI_INCR/CTI_EOB and BTE_LINEAR/BTE_WRAP4/8/16 localparams.
  - Responder state enum.
  - Wishbone width constants.
- One sub-module: zap_wb_burst_addr. Combinational next-address from (addr, bte) with wrap masking. It is shared with the initiators' burst generators.
- RAM array and FSM are inline.

Test Plan:
- WAIT_STATES=1, classic write adr 0x10, dat 0xDEADBEEF, sel 1111, then classic read 0x10 -> ack one cycle, 2 cycles after each request edge; read data 0xDEADBEEF.
- Byte-lane write sel=0010, dat 0x0000AA00, over 0x11223344 at 0x20; read back -> 0x1122AA44.
- Read burst cti=010, bte=01, start 0x38, 4 beats, last cti=111; RAM[i]=i*4 pattern -> 4 consecutive acks with data 0x38, 0x3C, 0x30, 0x34; then IDLE.
- Access at BASE_ADDR+4*DEPTH_WORDS -> o_wb_err=1 one cycle, ack=0, no RAM change; next valid read acks normally.
- Mid-burst stb=0 for 3 cycles -> no ack during the gap; burst resumes with the correct next address. Then cyc drop before a write beat -> no ack, target word unchanged.
- i_reset=0 asserted during the WAIT of a write -> ack/err/dat 0 after the edge, word unchanged; after reset release a new request completes normally.

Source files
------------

// File: rtl/zap_wb_pkg.sv
// Shared Wishbone B3 definitions for the ZAP memory-side initiators and responders.
package zap_wb_pkg;
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = WB_DAT_W / 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BEAT,
    ST_BURST
  } resp_state_t;
endpackage

// File: rtl/zap_wb_ram_responder_if.sv
// Wishbone B3 bus bundle between a ZAP initiator (master) and the RAM responder (slave).
interface zap_wb_ram_responder_if;
  import zap_wb_pkg::*;

  logic                i_wb_cyc;
  logic                i_wb_stb;
  logic                i_wb_wen;
  logic [WB_ADR_W-1:0] i_wb_adr;
  logic [WB_SEL_W-1:0] i_wb_sel;
  logic [WB_DAT_W-1:0] i_wb_dat;
  logic [2:0]          i_wb_cti;
  logic [1:0]          i_wb_bte;
  logic [WB_DAT_W-1:0] o_wb_dat;
  logic                o_wb_ack;
  logic                o_wb_err;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_adr, i_wb_sel, i_wb_dat, i_wb_cti, i_wb_bte,
    output o_wb_dat, o_wb_ack, o_wb_err
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_adr, i_wb_sel, i_wb_dat, i_wb_cti, i_wb_bte,
    input  o_wb_dat, o_wb_ack, o_wb_err
  );
endinterface

// File: rtl/zap_wb_burst_addr.sv
// Next burst beat address: +4 for linear bursts, wrapping inside a 4/8/16-word window otherwise.
module zap_wb_burst_addr
  import zap_wb_pkg::*;
(
  input  logic [WB_ADR_W-1:0] i_addr,
  input  logic [1:0]          i_bte,
  output logic [WB_ADR_W-1:0] o_addr
);
  logic [WB_ADR_W-1:0] w_inc;
  logic [WB_ADR_W-1:0] w_mask;

  assign w_inc = i_addr + WB_ADR_W'(4);

  // Mask selects which bits take the incremented value; the rest hold.
  always_comb begin
    w_mask = '1;
    case (i_bte)
      BTE_LINEAR: w_mask = '1;
      BTE_WRAP4:  w_mask = WB_ADR_W'(32'h0000_000C);
      BTE_WRAP8:  w_mask = WB_ADR_W'(32'h0000_001C);
      BTE_WRAP16: w_mask = WB_ADR_W'(32'h0000_003C);
      default:    w_mask = '1;
    endcase
  end

  assign o_addr = (i_addr & ~w_mask) | (w_inc & w_mask);
endmodule

// File: rtl/zap_wb_ram_responder.sv
// Wishbone B3 RAM responder with wait states, byte lanes, registered-feedback bursts
// and error termination for addresses outside the RAM window.
module zap_wb_ram_responder
  import zap_wb_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  zap_wb_ram_responder_if.slave  io_wb
);
  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [WB_DAT_W-1:0] r_mem [DEPTH_WORDS];

  resp_state_t         r_state, r_state_next;
  logic [3:0]          r_cnt, r_cnt_next;
  logic [WB_ADR_W-1:0] r_adr, r_adr_next;
  logic                r_wen, r_wen_next;
  logic [WB_SEL_W-1:0] r_sel, r_sel_next;
  logic [WB_DAT_W-1:0] r_dat, r_dat_next;
  logic [2:0]          r_cti, r_cti_next;
  logic [1:0]          r_bte, r_bte_next;
  logic                r_ack, r_ack_next;
  logic                r_err, r_err_next;
  logic [WB_DAT_W-1:0] r_rdat;

  logic                w_acc;
  logic [WB_ADR_W-1:0] w_acc_adr;
  logic                w_acc_wen;
  logic [WB_SEL_W-1:0] w_acc_sel;
  logic [WB_DAT_W-1:0] w_acc_dat;
  logic [WB_ADR_W-1:0] w_burst_adr;
  logic [WB_ADR_W-1:0] w_off;
  logic                w_in_range;
  logic [AW-1:0]       w_idx;
  logic                w_unused;

  zap_wb_burst_addr u_burst_addr (
    .i_addr (r_adr),
    .i_bte  (r_bte),
    .o_addr (w_burst_adr)
  );

  assign w_off      = w_acc_adr - BASE_ADDR;
  assign w_in_range = (w_off[WB_ADR_W-1:AW+2] == '0);
  assign w_idx      = w_off[AW+1:2];
  assign w_unused   = |w_off[1:0];

  always_comb begin
    r_state_next = r_state;
    r_cnt_next   = r_cnt;
    r_adr_next   = r_adr;
    r_wen_next   = r_wen;
    r_sel_next   = r_sel;
    r_dat_next   = r_dat;
    r_cti_next   = r_cti;
    r_bte_next   = r_bte;
    w_acc        = 1'b0;
    w_acc_adr    = r_adr;
    w_acc_wen    = r_wen;
    w_acc_sel    = r_sel;
    w_acc_dat    = r_dat;

    case (r_state)
      ST_IDLE: begin
        if (io_wb.i_wb_cyc && io_wb.i_wb_stb) begin
          r_adr_next = io_wb.i_wb_adr;
          r_wen_next = io_wb.i_wb_wen;
          r_sel_next = io_wb.i_wb_sel;
          r_dat_next = io_wb.i_wb_dat;
          r_cti_next = io_wb.i_wb_cti;
          r_bte_next = io_wb.i_wb_bte;
          if (WAIT_STATES == 0) begin
            w_acc        = 1'b1;
            w_acc_adr    = io_wb.i_wb_adr;
            w_acc_wen    = io_wb.i_wb_wen;
            w_acc_sel    = io_wb.i_wb_sel;
            w_acc_dat    = io_wb.i_wb_dat;
            r_state_next = ST_BEAT;
          end else begin
            r_cnt_next   = WS_LOAD;
            r_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!io_wb.i_wb_cyc) begin
          r_state_next = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_acc        = 1'b1;
          r_state_next = ST_BEAT;
        end else begin
          r_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_BEAT, ST_BURST: begin
        if (!io_wb.i_wb_cyc) begin
          r_state_next = ST_IDLE;
        end else if (r_state == ST_BURST || r_cti == CTI_INCR) begin
          // The ack cycle of a burst beat doubles as the sampling cycle of the next beat.
          if (io_wb.i_wb_stb) begin
            w_acc      = 1'b1;
            w_acc_adr  = w_burst_adr;
            w_acc_sel  = io_wb.i_wb_sel;
            w_acc_dat  = io_wb.i_wb_dat;
            r_adr_next = w_burst_adr;
            if (io_wb.i_wb_cti == CTI_INCR) begin
              r_cti_next   = CTI_INCR;
              r_state_next = ST_BURST;
            end else begin
              r_cti_next   = CTI_EOB;
              r_state_next = ST_BEAT;
            end
          end else begin
            r_state_next = ST_BURST;
          end
        end else begin
          r_state_next = ST_IDLE;
        end
      end
      default: r_state_next = ST_IDLE;
    endcase

    if (w_acc && !w_in_range) begin
      r_cti_next   = CTI_CLASSIC;
      r_state_next = ST_BEAT;
    end

    r_ack_next = w_acc && w_in_range;
    r_err_next = w_acc && !w_in_range;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_wen   <= 1'b0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_cti   <= CTI_CLASSIC;
      r_bte   <= BTE_LINEAR;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdat  <= '0;
    end else begin
      r_state <= r_state_next;
      r_cnt   <= r_cnt_next;
      r_adr   <= r_adr_next;
      r_wen   <= r_wen_next;
      r_sel   <= r_sel_next;
      r_dat   <= r_dat_next;
      r_cti   <= r_cti_next;
      r_bte   <= r_bte_next;
      r_ack   <= r_ack_next;
      r_err   <= r_err_next;
      r_rdat  <= (w_acc && w_in_range && !w_acc_wen) ? r_mem[w_idx] : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset && w_acc && w_in_range && w_acc_wen) begin
      for (int li = 0; li < WB_SEL_W; li++) begin
        if (w_acc_sel[li]) begin
          r_mem[w_idx][8*li +: 8] <= w_acc_dat[8*li +: 8];
        end
      end
    end
  end

  assign io_wb.o_wb_ack = r_ack;
  assign io_wb.o_wb_err = r_err;
  assign io_wb.o_wb_dat = r_rdat;
endmodule
